// File: rtl/sram_bridge_pkg.sv
// Shared types and defaults for the 1R1W SRAM requester bridge.
package sram_bridge_pkg;

    // Default geometry: 512 x 49 array with a two-entry response buffer.
    localparam int ADDR_W_DEF     = 9;
    localparam int DATA_W_DEF     = 49;
    localparam int RESP_DEPTH_DEF = 2;

    // Controller phases: zeroing sweep after reset, then normal service.
    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Width needed to count 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sram_bridge_resp_fifo.sv
// Small register-based response FIFO. The head is always presented from a
// storage register so downstream logic never sees the macro read path.
module sram_bridge_resp_fifo
    import sram_bridge_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = RESP_DEPTH_DEF,
    localparam int CNT_W  = cnt_width(DEPTH),
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  occupancy,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] entry_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [DEPTH-1:0]  wr_sel;
    logic              pop_eff;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign occupancy = count_reg;
    assign pop_eff   = pop && !empty;
    assign head_data = entry_reg[rd_ptr_reg];

    // One write-select line per storage slot.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
        assign wr_sel[gi] = push && (wr_ptr_reg == PTR_W'(gi));
    end

    // Storage slots: data only, no reset needed since count gates validity.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                entry_reg[i] <= push_data;
            end
        end
    end

    // Occupancy update; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push, pop_eff})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            assert (!(push && full && !pop_eff));
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop_eff) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/sram_1r1w_bridge.sv
// Requester-side controller for a 1R1W synchronous SRAM macro: zeroes the
// array after reset, turns decoupled reads into macro port activity with a
// credit-checked response FIFO, and passes writes straight through.
// Build option SRAM_BRIDGE_WR_FWD_EN: a read colliding with a same-cycle write
// to the same address fires anyway and returns the written data from a
// forward register; without it the colliding read is held off one cycle.
module sram_1r1w_bridge
    import sram_bridge_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RESP_DEPTH = RESP_DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_done,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [DATA_W-1:0] rd_resp_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              R0_en,
    output logic [ADDR_W-1:0] R0_addr,
    input  logic [DATA_W-1:0] R0_data,
    output logic              W0_en,
    output logic [ADDR_W-1:0] W0_addr,
    output logic [DATA_W-1:0] W0_data
);

    localparam int                CNT_W     = cnt_width(RESP_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [CNT_W:0]    DEPTH_LIM = (CNT_W + 1)'(RESP_DEPTH);

    state_e            state_reg;
    state_e            state_next;
    logic [ADDR_W-1:0] sweep_cnt_reg;
    logic [ADDR_W-1:0] sweep_cnt_next;
    logic              inflight_reg;

    logic              in_run;
    logic              collide;
    logic              deq;
    logic              rd_fire;
    logic [CNT_W:0]    pending;
    logic              credit_ok;
    logic [DATA_W-1:0] push_data;
    logic [CNT_W-1:0]  fifo_occ;
    logic              fifo_full;
    logic              fifo_empty;

    // Outputs are suppressed while reset is held, regardless of state.
    assign in_run  = (state_reg == S_RUN) && !reset;
    assign collide = rd_req_valid && wr_valid && (rd_req_addr == wr_addr);

    assign rd_resp_valid = !fifo_empty && !reset;
    assign deq           = rd_resp_valid && rd_resp_ready;

    // Outstanding work = buffered + returning next cycle - leaving this cycle.
    assign pending   = {1'b0, fifo_occ}
                     + {{CNT_W{1'b0}}, inflight_reg}
                     - {{CNT_W{1'b0}}, deq};
    assign credit_ok = (pending < DEPTH_LIM);

`ifdef SRAM_BRIDGE_WR_FWD_EN
    assign rd_req_ready = in_run && credit_ok;
`else
    assign rd_req_ready = in_run && credit_ok && !collide;
`endif

    assign rd_fire = rd_req_valid && rd_req_ready;
    assign R0_en   = rd_fire;
    assign R0_addr = rd_req_addr;

    // Next-state and write-port steering: sweep in INIT, pass-through in RUN.
    always_comb begin
        state_next     = state_reg;
        sweep_cnt_next = sweep_cnt_reg;
        init_done      = 1'b0;
        W0_en          = 1'b0;
        W0_addr        = '0;
        W0_data        = '0;
        case (state_reg)
            S_INIT: begin
                W0_en          = !reset;
                W0_addr        = sweep_cnt_reg;
                W0_data        = '0;
                sweep_cnt_next = sweep_cnt_reg + 1'b1;
                if (sweep_cnt_reg == LAST_ADDR) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                init_done = !reset;
                W0_en     = wr_valid && !reset;
                W0_addr   = wr_addr;
                W0_data   = wr_data;
            end
            default: begin
                state_next = S_INIT;
            end
        endcase
    end

    // State, sweep counter and in-flight flag; reset restarts the sweep.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= S_INIT;
            sweep_cnt_reg <= '0;
            inflight_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sweep_cnt_reg <= sweep_cnt_next;
            inflight_reg  <= rd_fire;
        end
    end

`ifdef SRAM_BRIDGE_WR_FWD_EN
    logic              fwd_hit_reg;
    logic [DATA_W-1:0] fwd_data_reg;

    // Capture write data for a colliding read so the macro's
    // read-during-write behaviour never matters.
    always_ff @(posedge clock) begin
        if (reset) begin
            fwd_hit_reg <= 1'b0;
        end else begin
            fwd_hit_reg <= rd_fire && collide;
        end
        if (rd_fire && collide) begin
            fwd_data_reg <= wr_data;
        end
    end

    assign push_data = fwd_hit_reg ? fwd_data_reg : R0_data;
`else
    assign push_data = R0_data;
`endif

    sram_bridge_resp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RESP_DEPTH)
    ) u_resp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight_reg),
        .push_data (push_data),
        .pop       (deq),
        .head_data (rd_resp_data),
        .occupancy (fifo_occ),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The credit check keeps the FIFO from overflowing, so full is only
    // consumed by the FIFO's own guard.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_sram_1r1w_bridge.sv
// Self-checking bench for sram_1r1w_bridge with a behavioural macro model,
// a reference memory and a response scoreboard.
module tb_sram_1r1w_bridge;

    localparam int AW    = 9;
    localparam int DW    = 49;
    localparam int DEPTH = 1 << AW;
    localparam int RD    = 2;

    logic          clock;
    logic          reset;
    logic          init_done;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [AW-1:0] rd_req_addr;
    logic          rd_resp_valid;
    logic          rd_resp_ready;
    logic [DW-1:0] rd_resp_data;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          R0_en;
    logic [AW-1:0] R0_addr;
    logic [DW-1:0] R0_data;
    logic          W0_en;
    logic [AW-1:0] W0_addr;
    logic [DW-1:0] W0_data;

    sram_1r1w_bridge #(.ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(RD)) dut (
        .clock         (clock),
        .reset         (reset),
        .init_done     (init_done),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_ready (rd_resp_ready),
        .rd_resp_data  (rd_resp_data),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .R0_en         (R0_en),
        .R0_addr       (R0_addr),
        .R0_data       (R0_data),
        .W0_en         (W0_en),
        .W0_addr       (W0_addr),
        .W0_data       (W0_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Macro model: registered read address, old data on read-during-write.
    logic [DW-1:0] macro_mem [DEPTH];
    always @(posedge clock) begin
        if (W0_en) macro_mem[W0_addr] <= W0_data;
        if (R0_en) R0_data <= macro_mem[R0_addr];
    end

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            since_rst = 0;
    int            fire_cnt = 0;
    int            resp_cnt = 0;
    int            lat_bad = 0;
    int            last_latency = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rnd49();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) since_rst <= 0;
        else       since_rst <= since_rst + 1;
    end

    // Monitor: checks every cycle against the reference rules.
    exp_t          e;
    logic          exp_rv, exp_rdy, m_deq, m_fire, m_coll;
    logic [DW-1:0] exp_data;
    always @(negedge clock) begin
        if (reset) begin
            sbq.delete();
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            chk("rst_init_done", init_done, 0);
            chk("rst_req_ready", rd_req_ready, 0);
            chk("rst_resp_valid", rd_resp_valid, 0);
            chk("rst_r0_en", R0_en, 0);
            chk("rst_w0_en", W0_en, 0);
        end else if (since_rst < DEPTH) begin
            chk("init_done_low", init_done, 0);
            chk("init_req_ready", rd_req_ready, 0);
            chk("init_r0_en", R0_en, 0);
            chk("init_resp_valid", rd_resp_valid, 0);
            chk("sweep_w0_en", W0_en, 1);
            chk("sweep_w0_addr", W0_addr, 64'(since_rst));
            chk("sweep_w0_data", W0_data, 0);
        end else begin
            m_coll  = rd_req_valid && wr_valid && (rd_req_addr == wr_addr);
            exp_rv  = (sbq.size() > 0) && (sbq[0].cyc <= cyc - 2);
            m_deq   = exp_rv && rd_resp_ready;
`ifdef SRAM_BRIDGE_WR_FWD_EN
            exp_rdy = (sbq.size() - int'(m_deq)) < RD;
`else
            exp_rdy = ((sbq.size() - int'(m_deq)) < RD) && !m_coll;
`endif
            m_fire  = rd_req_valid && exp_rdy;
            chk("init_done", init_done, 1);
            chk("resp_valid", rd_resp_valid, exp_rv);
            chk("req_ready", rd_req_ready, exp_rdy);
            chk("r0_en", R0_en, m_fire);
            if (m_fire) chk("r0_addr", R0_addr, rd_req_addr);
            chk("w0_en", W0_en, wr_valid);
            if (wr_valid) begin
                chk("w0_addr", W0_addr, wr_addr);
                chk("w0_data", W0_data, wr_data);
            end
            if (m_deq) begin
                e = sbq.pop_front();
                chk("resp_data", rd_resp_data, e.data);
                last_latency = cyc - e.cyc;
                if (last_latency != 2) lat_bad++;
                resp_cnt++;
            end
            if (m_fire) begin
                exp_data = (wr_valid && wr_addr == rd_req_addr) ? wr_data : ref_mem[rd_req_addr];
                sbq.push_back('{data: exp_data, cyc: cyc});
                fire_cnt++;
            end
            if (wr_valid) ref_mem[wr_addr] = wr_data;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    int fb, rb;

    initial begin
        for (int i = 0; i < DEPTH; i++) macro_mem[i] = rnd49();
        reset = 1'b1;
        rd_req_valid = 0; rd_req_addr = '0; rd_resp_ready = 1'b1;
        wr_valid = 0; wr_addr = '0; wr_data = '0;
        repeat (3) step();
        reset = 1'b0;
        // Requests during the sweep must be ignored.
        rd_req_valid = 1'b1; rd_req_addr = 9'h1FF;
        wr_valid = 1'b1; wr_addr = 9'h005; wr_data = rnd49();
        repeat (DEPTH) step();
        wr_valid = 1'b0;
        step();
        rd_req_valid = 1'b0;
        repeat (4) step();

        // Write then read back with minimum latency.
        wr_valid = 1'b1; wr_addr = 9'h00A; wr_data = 49'h1_2345_6789_ABCD;
        step();
        wr_valid = 1'b0; rd_req_valid = 1'b1; rd_req_addr = 9'h00A;
        rb = resp_cnt;
        step();
        rd_req_valid = 1'b0;
        repeat (3) step();
        chk("wr_rd_latency", 64'(last_latency), 2);
        chk("wr_rd_count", 64'(resp_cnt - rb), 1);

        // Back-to-back reads with an always-ready consumer.
        lat_bad = 0; rb = resp_cnt; fb = fire_cnt;
        for (int i = 0; i < 8; i++) begin
            rd_req_valid = 1'b1; rd_req_addr = AW'(i);
            step();
        end
        rd_req_valid = 1'b0;
        repeat (4) step();
        chk("b2b_fires", 64'(fire_cnt - fb), 8);
        chk("b2b_resps", 64'(resp_cnt - rb), 8);
        chk("b2b_bubbles", 64'(lat_bad), 0);

        // Backpressure: only RESP_DEPTH reads may be accepted.
        rd_resp_ready = 1'b0; fb = fire_cnt;
        for (int i = 0; i < 6; i++) begin
            rd_req_valid = 1'b1; rd_req_addr = AW'(9'h020 + i);
            step();
        end
        chk("bp_fires", 64'(fire_cnt - fb), RD);
        chk("bp_ready_low", rd_req_ready, 0);
        rd_resp_ready = 1'b1; fb = fire_cnt;
        repeat (4) step();
        chk("bp_resume", 64'(fire_cnt - fb > 2), 1);
        rd_req_valid = 1'b0;
        repeat (4) step();

        // Same-cycle read and write to one address.
        rd_req_valid = 1'b1; rd_req_addr = 9'h033;
        wr_valid = 1'b1; wr_addr = 9'h033; wr_data = 49'h5;
        #1;
`ifdef SRAM_BRIDGE_WR_FWD_EN
        chk("coll_ready", rd_req_ready, 1);
        step();
        wr_valid = 1'b0; rd_req_valid = 1'b0;
`else
        chk("coll_ready", rd_req_ready, 0);
        step();
        wr_valid = 1'b0;
        #1;
        chk("coll_retry_ready", rd_req_ready, 1);
        step();
        rd_req_valid = 1'b0;
`endif
        repeat (4) step();

        // Randomised traffic over a narrow address window to force hazards.
        for (int i = 0; i < 3000; i++) begin
            rd_req_valid  = ($urandom_range(9) < 6);
            rd_req_addr   = AW'($urandom_range(15));
            wr_valid      = ($urandom_range(1) == 1);
            wr_addr       = AW'($urandom_range(15));
            wr_data       = rnd49();
            rd_resp_ready = ($urandom_range(9) < 7);
            step();
        end
        rd_req_valid = 1'b0; wr_valid = 1'b0; rd_resp_ready = 1'b1;
        repeat (6) step();

        // Reset with one read buffered and one in flight.
        rd_resp_ready = 1'b0;
        rd_req_valid = 1'b1; rd_req_addr = 9'h001;
        step();
        rd_req_addr = 9'h002;
        step();
        rd_req_valid = 1'b0;
        reset = 1'b1;
        rd_resp_ready = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        repeat (DEPTH + 4) step();

        // Drain with a bounded wait.
        for (int i = 0; i < 50 && sbq.size() != 0; i++) step();
        chk("final_drain", 64'(sbq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
